// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives every datapath select and strobe, and counts retired instructions.
module mips_mc_control #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       ula_operation,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] FETCH     = 4'd0;
    localparam logic [3:0] DECODE    = 4'd1;
    localparam logic [3:0] MEM_ADDR  = 4'd2;
    localparam logic [3:0] MEM_READ  = 4'd3;
    localparam logic [3:0] MEM_WB    = 4'd4;
    localparam logic [3:0] MEM_WRITE = 4'd5;
    localparam logic [3:0] R_EXEC    = 4'd6;
    localparam logic [3:0] R_WB      = 4'd7;
    localparam logic [3:0] BRANCH    = 4'd8;
    localparam logic [3:0] JUMP      = 4'd9;
    localparam logic [3:0] ADDI_EXEC = 4'd10;
    localparam logic [3:0] ADDI_WB   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [3:0] cur_state;
    logic [3:0] nxt_state;
    logic       retire;

    always_comb begin
        nxt_state = FETCH;
        retire    = 1'b0;
        case (cur_state)
            FETCH:     nxt_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     nxt_state = R_EXEC;
                    OP_LW, OP_SW: nxt_state = MEM_ADDR;
                    OP_BEQ:       nxt_state = BRANCH;
                    OP_J:         nxt_state = JUMP;
                    OP_ADDI:      nxt_state = ADDI_EXEC;
                    default:      nxt_state = FETCH;
                endcase
            end
            // IR is not reloaded after FETCH, so opcode is still the lw/sw seen in DECODE
            MEM_ADDR:  nxt_state = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  nxt_state = mem_ready ? MEM_WB : MEM_READ;
            MEM_WRITE: begin
                nxt_state = mem_ready ? FETCH : MEM_WRITE;
                retire    = mem_ready;
            end
            R_EXEC:    nxt_state = R_WB;
            ADDI_EXEC: nxt_state = ADDI_WB;
            MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: begin
                nxt_state = FETCH;
                retire    = 1'b1;
            end
            default:   nxt_state = FETCH;
        endcase
    end

    // Every output is held low while reset is asserted, independent of the clock
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        ula_operation = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        if (reset) begin
            case (cur_state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    alu_src_b  = 2'b11;
                    illegal_op = !(opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
                end
                MEM_ADDR, ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                R_EXEC: begin
                    alu_src_a     = 1'b1;
                    ula_operation = 2'b10;
                end
                R_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    ula_operation = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                ADDI_WB:  reg_write = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_state   <= FETCH;
            instr_count <= '0;
        end else begin
            cur_state <= nxt_state;
            if (retire) instr_count <= instr_count + CNT_W'(1);
        end
    end

    assign state = cur_state;

endmodule
